// File: rtl/register_input.sv
// CPU-readable debounced button/switch register with sticky press flags on the shared 8-bit bus.
// Optional press-flag logic is built only when INPUT_PORT_EDGE_EN is defined.
module register_input #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_pins,
  input  logic             i_read_n,
  input  logic             i_read_flags_n,
  inout  wire  [7:0]       io_bus,
  output logic             o_pending,
  output logic [7:0]       internal_data
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] accept;
  logic [CW-1:0]    cnt [WIDTH];
  logic [7:0]       val8;
  logic [7:0]       flag8;

  // Pins idle high (released), so the synchroniser resets to all ones.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= i_pins;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_deb
    assign accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset)
        cnt[i] <= '0;
      else if ((sync2[i] == stable[i]) || accept[i])
        cnt[i] <= '0;
      else
        cnt[i] <= cnt[i] + CW'(1);
    end
  end

  // An accepted bit always differs from its stable level, so toggling it takes the new level.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      stable <= '1;
    else
      stable <= stable ^ accept;
  end

  always_comb begin
    val8             = '0;
    val8[WIDTH-1:0]  = ~stable;
  end

  assign internal_data = val8;

`ifdef INPUT_PORT_EDGE_EN
  logic [WIDTH-1:0] flags;
  logic [WIDTH-1:0] press;

  // A press is an accepted transition out of the released (high) level.
  assign press = accept & stable;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)
      flags <= '0;
    else
      flags <= (i_read_flags_n ? flags : '0) | press;
  end

  assign o_pending = |flags;

  always_comb begin
    flag8            = '0;
    flag8[WIDTH-1:0] = flags;
  end
`else
  assign o_pending = 1'b0;
  assign flag8     = 8'h00;
`endif

  assign io_bus = !i_read_flags_n ? flag8 :
                  !i_read_n       ? val8  : 8'hzz;

endmodule

// File: tb/tb_register_input.sv
// Randomised and directed bench for register_input against a sample-window reference model.
module tb_register_input;

  localparam int W  = 4;
  localparam int DC = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] pins;
  logic         rd_n;
  logic         rdf_n;
  wire  [7:0]   bus;
  logic         pending;
  logic [7:0]   data;

  int n_cmp;
  int n_bad;

  register_input #(.WIDTH(W), .DEBOUNCE_CYCLES(DC)) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_pins(pins),
    .i_read_n(rd_n),
    .i_read_flags_n(rdf_n),
    .io_bus(bus),
    .o_pending(pending),
    .internal_data(data)
  );

  // Undriven bus bits read back as 1.
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup (bus[g]);
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: stable level plus a history of pin samples taken at each edge.
  logic [W-1:0] m_stable;
  logic [W-1:0] m_flags;
  logic [W-1:0] hist [$];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stable = '1;
    m_flags  = '0;
    hist.delete();
    for (int j = 0; j < DC + 2; j++) hist.push_back('1);
  endtask

  // A level is accepted when the DC samples taken two to DC+1 edges ago all disagree with stable.
  task automatic model_edge(input logic [W-1:0] p, input logic rfn);
    logic [W-1:0] acc;
    for (int b = 0; b < W; b++) begin
      acc[b] = 1'b1;
      for (int j = 1; j <= DC; j++)
        if (hist[j][b] == m_stable[b]) acc[b] = 1'b0;
    end
`ifdef INPUT_PORT_EDGE_EN
    m_flags = (rfn ? m_flags : '0) | (acc & m_stable);
`endif
    m_stable = m_stable ^ acc;
    hist.push_front(p);
    void'(hist.pop_back());
  endtask

  function automatic logic [7:0] exp_val();
    logic [7:0] v;
    v = '0;
    v[W-1:0] = ~m_stable;
    return v;
  endfunction

  function automatic logic [7:0] exp_bus(input logic rn, input logic rfn);
    logic [7:0] f;
    f = '0;
    f[W-1:0] = m_flags;
    if (!rfn) return f;
    if (!rn)  return exp_val();
    return 8'hFF;
  endfunction

  task automatic cyc(input logic [W-1:0] p, input logic rn, input logic rfn, output logic [7:0] seen);
    pins  = p;
    rd_n  = rn;
    rdf_n = rfn;
    @(negedge clk);
    seen = bus;
    check("value", data, exp_val());
    check("pending", {7'd0, pending}, {7'd0, |m_flags});
    check("bus", bus, exp_bus(rn, rfn));
    @(posedge clk);
    model_edge(p, rfn);
    #1;
  endtask

  task automatic run(input logic [W-1:0] p, input logic rn, input logic rfn, input int n);
    logic [7:0] s;
    for (int k = 0; k < n; k++) cyc(p, rn, rfn, s);
  endtask

  initial begin
    logic [7:0] seen;
    logic [W-1:0] rp;
    int len;
    int r;
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    pins  = '1;
    rd_n  = 1'b1;
    rdf_n = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state, bus released
    cyc(4'hF, 1'b1, 1'b1, seen);
    check("reset_bus_z", seen, 8'hFF);
    check("reset_data", data, 8'h00);
    run(4'hF, 1'b1, 1'b1, 3);

    // Clean press on bit 0; per-cycle checks catch early or late acceptance
    run(4'hE, 1'b1, 1'b1, 20);
    cyc(4'hE, 1'b0, 1'b1, seen);
    check("value_read", seen, 8'h01);

    // Glitches on bit 1 while bit 0 stays pressed
    run(4'hC, 1'b1, 1'b1, 10);
    run(4'hE, 1'b1, 1'b1, 20);
    run(4'hC, 1'b1, 1'b1, 15);
    run(4'hE, 1'b1, 1'b1, 20);
    check("glitch15", data, 8'h01);
    run(4'hC, 1'b1, 1'b1, 17);
    run(4'hE, 1'b1, 1'b1, 20);

    // Release all, clear flags, then press bit 2 and read flags twice
    run(4'hF, 1'b1, 1'b1, 20);
    run(4'hF, 1'b1, 1'b0, 1);
    run(4'hB, 1'b1, 1'b1, 20);
    cyc(4'hB, 1'b1, 1'b0, seen);
`ifdef INPUT_PORT_EDGE_EN
    check("flag_rd", seen, 8'h04);
`else
    check("flag_rd", seen, 8'h00);
`endif
    cyc(4'hB, 1'b1, 1'b0, seen);
    check("flag_rd2", seen, 8'h00);
    check("flag_rd2_val", data, 8'h04);

    // Bit 3 completes debounce on the edge that clears the bit 0 flag
    run(4'hF, 1'b1, 1'b1, 20);
    run(4'hF, 1'b1, 1'b0, 1);
    run(4'hE, 1'b1, 1'b1, 20);
    run(4'h6, 1'b1, 1'b1, 17);
    cyc(4'h6, 1'b1, 1'b0, seen);
    cyc(4'h6, 1'b1, 1'b0, seen);
`ifdef INPUT_PORT_EDGE_EN
    check("collision", seen, 8'h08);
`else
    check("collision", seen, 8'h00);
`endif

    // Asynchronous reset mid-debounce
    run(4'h0, 1'b1, 1'b1, 20);
    run(4'hF, 1'b1, 1'b1, 8);
    #2 rst = 1'b1;
    #1;
    check("arst_data", data, 8'h00);
    check("arst_pending", {7'd0, pending}, 8'h00);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    run(4'h0, 1'b1, 1'b1, 25);

    // Random pin patterns with occasional reads
    for (int s = 0; s < 60; s++) begin
      rp  = W'($urandom);
      len = $urandom_range(1, 24);
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 9);
        cyc(rp, r != 0, r != 1, seen);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/register_input.md
# register_input

Memory-mapped-style input register that lets the CPU read physical buttons/switches over the shared 8-bit bus. It is the input counterpart of the output register that drives the LEDs. Raw active-low pin levels are synchronised and debounced per bit, then presented as a stable logical value. Sticky press-event flags are also kept, so the controller can poll for presses without missing short events.

## Interface
Parameters:
- WIDTH, 4: number of input pins (1..8); bus bits [7:WIDTH] read as 0.
- DEBOUNCE_CYCLES, 16: consecutive agreeing synchronised samples required to accept a level change (2..65535).

Ports:
- i_clk  input  1  system clock; all state on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_pins  input  WIDTH  raw pin levels, active-low (0 = pressed), asynchronous to i_clk.
- i_read_n  input  1  active-low; drive debounced value onto io_bus.
- i_read_flags_n  input  1  active-low; drive press flags onto io_bus and clear them.
- io_bus  inout  8  shared CPU bus; high-Z unless a read strobe is low.
- o_pending  output  1  OR of all press flags.
- internal_data  output  8  debounced logical value, zero-extended to 8 bits (1 = pressed).

## Operation
- Per bit: two-flop synchroniser → debounce counter → stable flop. Logical value v[i] = ~stable[i].
- The counter increments each cycle while the synchronised level differs from the stable level. It clears to 0 whenever they agree.
- When the counter equals DEBOUNCE_CYCLES-1 and the levels still differ, the stable flop takes the synchronised level on that edge and the counter clears.
- A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never reaches stable. Any agreeing sample restarts the count.
- Counter width is ceil(log2(DEBOUNCE_CYCLES)). The counter never wraps, because it clears on acceptance.
- Press flag f[i] sets on the edge where v[i] goes 0→1. Release (1→0) does not set it. Flags are sticky until read.
- Read value (i_read_n=0, i_read_flags_n=1): io_bus = {0, v}, combinational. No state change.
- Read flags (i_read_flags_n=0): io_bus = {0, f}, combinational. Every flag clears on the next rising edge while the strobe is low.
- Simultaneous set and clear on the same edge: set wins, so the new press stays pending.
- Both strobes low: flags are driven and cleared; the value is not driven. The controller must not do this.
- Both strobes high: io_bus = 8'hZZ.

## Timing
- Reset values:
  - synchroniser and stable flops = all 1 (released);
  - counters = 0; flags = 0;
  - internal_data = 8'h00; o_pending = 0; io_bus = Z.
- Assertion of i_reset mid-debounce discards the count and pending flags immediately. This does not depend on the clock.
- Pin-to-value latency: for a pin change settled before edge k, v updates on edge k+1+DEBOUNCE_CYCLES. It is visible on internal_data and the bus after that edge.
- f[i] and o_pending go high on the same edge as v[i] rises.
- Bus output follows the strobes combinationally; there is no registered read latency. Data is valid in the same cycle the strobe is low.
- The flag clear takes effect on the edge that ends the read cycle. The value driven during that cycle is the pre-clear value.

## Configuration
- INPUT_PORT_EDGE_EN defined: press flags, o_pending and the flag-read path are built as described.
- INPUT_PORT_EDGE_EN not defined:
  - no flag storage is built;
  - o_pending is constant 0;
  - i_read_flags_n low drives 8'h00 onto io_bus;
  - the debounced value path is unchanged.

## Test plan
- Reset: with i_pins=4'hF, release i_reset → internal_data=8'h00, o_pending=0, io_bus=Z with both strobes high.
- Clean press: WIDTH=4, DEBOUNCE_CYCLES=16, drive i_pins=4'hE before edge k → internal_data=8'h01 and o_pending=1 exactly at edge k+17, not earlier. A value read then returns 8'h01.
- Glitch rejection: pull i_pins[1] low for 10 cycles, then high → internal_data stays 8'h00 and o_pending stays 0. A 15-cycle pulse is also rejected; a 17-cycle pulse is accepted.
- Flag read/clear: after a press on bit 2, hold i_read_flags_n low for one cycle → bus=8'h04 during the cycle, then o_pending=0. A second flag read returns 8'h00 while internal_data still shows 8'h04.
- Set/clear collision: complete debounce of bit 3 on the same edge as a flag read of bit 0 → the post-edge flags equal 8'h08.
- Macro off: build without INPUT_PORT_EDGE_EN and press bit 0 → internal_data=8'h01, o_pending=0, and a flag read returns 8'h00.
